// File: rtl/waveform_pwm_output_if.sv
// Sample handshake between the waveform generator and the PWM output stage.
// The generator (master) presents three signed sample streams, each with its
// own one-cycle valid strobe, and receives one sample request per PWM period.
interface waveform_pwm_output_if #(
   parameter int N_FRAC = 7
);

   logic signed [N_FRAC:0] data_sawtooth_i;
   logic                   data_sawtooth_valid_strobe_i;
   logic signed [N_FRAC:0] data_triangle_i;
   logic                   data_triangle_valid_strobe_i;
   logic signed [N_FRAC:0] data_square_puls_i;
   logic                   data_square_puls_valid_strobe_i;
   logic                   next_data_strobe_o;

   modport master (
      output data_sawtooth_i,
      output data_sawtooth_valid_strobe_i,
      output data_triangle_i,
      output data_triangle_valid_strobe_i,
      output data_square_puls_i,
      output data_square_puls_valid_strobe_i,
      input  next_data_strobe_o
   );

   modport slave (
      input  data_sawtooth_i,
      input  data_sawtooth_valid_strobe_i,
      input  data_triangle_i,
      input  data_triangle_valid_strobe_i,
      input  data_square_puls_i,
      input  data_square_puls_valid_strobe_i,
      output next_data_strobe_o
   );

endinterface

// File: rtl/waveform_pwm_output.sv
// PWM output stage for the waveform generator.
// Selects one of three signed sample streams, latches one sample per PWM
// period and emits a single-bit PWM whose duty is the sample in offset
// binary. One request strobe per period paces the generator, and a sticky
// flag records any period that started without a fresh selected sample.
module waveform_pwm_output #(
   parameter int N_FRAC = 7
) (
   input  logic                   clk_i,
   input  logic                   rst_i,
   input  logic [1:0]             wave_select_i,
   waveform_pwm_output_if.slave   gen,
   output logic signed [N_FRAC:0] sample_o,
   output logic                   sample_valid_strobe_o,
   output logic                   pwm_o,
   output logic                   underrun_o
);

   localparam logic [N_FRAC:0] CNT_LAST = '1;
   localparam logic [1:0]      SEL_SAW  = 2'b00;
   localparam logic [1:0]      SEL_TRI  = 2'b01;
   localparam logic [1:0]      SEL_SQR  = 2'b10;
   localparam logic [1:0]      SEL_MUTE = 2'b11;

   typedef enum logic [0:0] {
      RESET,
      RUN
   } state_t;

   state_t                 state;
   logic [N_FRAC:0]        cnt;
   logic [1:0]             sel;
   logic signed [N_FRAC:0] pending;
   logic                   fresh;

   logic                   sel_strobe;
   logic signed [N_FRAC:0] sel_data;
   logic [N_FRAC:0]        duty;
   logic                   wrap;

   // Route the stream chosen by the period's select register; mute has no strobe.
   always_comb begin
      sel_strobe = 1'b0;
      sel_data   = '0;
      case (sel)
         SEL_SAW: begin
            sel_strobe = gen.data_sawtooth_valid_strobe_i;
            sel_data   = gen.data_sawtooth_i;
         end
         SEL_TRI: begin
            sel_strobe = gen.data_triangle_valid_strobe_i;
            sel_data   = gen.data_triangle_i;
         end
         SEL_SQR: begin
            sel_strobe = gen.data_square_puls_valid_strobe_i;
            sel_data   = gen.data_square_puls_i;
         end
         default: begin
            sel_strobe = 1'b0;
            sel_data   = '0;
         end
      endcase
   end

   // Offset-binary duty: flipping the sign bit maps -MID..MID-1 onto 0..P-1.
   assign duty = {~sample_o[N_FRAC], sample_o[N_FRAC-1:0]};
   assign wrap = (cnt == CNT_LAST);

   // Period FSM: RESET spends the release edge priming the first request, RUN
   // counts periods, captures samples, loads sample_o at the wrap and drives PWM.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state                  <= RESET;
         cnt                    <= '0;
         sel                    <= SEL_MUTE;
         pending                <= '0;
         fresh                  <= 1'b0;
         sample_o               <= '0;
         sample_valid_strobe_o  <= 1'b0;
         pwm_o                  <= 1'b0;
         gen.next_data_strobe_o <= 1'b0;
         underrun_o             <= 1'b0;
      end else begin
         case (state)
            RESET: begin
               state                  <= RUN;
               cnt                    <= '0;
               pwm_o                  <= 1'b0;
               sample_valid_strobe_o  <= 1'b0;
               gen.next_data_strobe_o <= 1'b1;
            end
            RUN: begin
               pwm_o <= (cnt < duty);
               if (wrap) begin
                  cnt                    <= '0;
                  sel                    <= wave_select_i;
                  fresh                  <= 1'b0;
                  gen.next_data_strobe_o <= 1'b1;
                  if (sel == SEL_MUTE) begin
                     sample_o              <= '0;
                     sample_valid_strobe_o <= 1'b1;
                  end else if (sel_strobe) begin
                     sample_o              <= sel_data;
                     sample_valid_strobe_o <= 1'b1;
                  end else if (fresh) begin
                     sample_o              <= pending;
                     sample_valid_strobe_o <= 1'b1;
                  end else begin
                     sample_valid_strobe_o <= 1'b0;
                     underrun_o            <= 1'b1;
                  end
               end else begin
                  cnt                    <= cnt + 1'b1;
                  gen.next_data_strobe_o <= 1'b0;
                  sample_valid_strobe_o  <= 1'b0;
                  if (sel_strobe) begin
                     pending <= sel_data;
                     fresh   <= 1'b1;
                  end
               end
            end
            default: begin
               state <= RESET;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_waveform_pwm_output.sv
// Self-checking bench for waveform_pwm_output.
// A small generator model answers each request strobe at a chosen period
// position; expected sample_o values are queued per wrap and compared whenever
// the DUT pulses sample_valid_strobe_o. Each scenario task checks its own results.
module tb_waveform_pwm_output;

   localparam int N_FRAC = 7;

   logic                   clk = 1'b0;
   logic                   rst = 1'b1;
   logic [1:0]             wave_select = 2'b11;
   logic signed [N_FRAC:0] sample;
   logic                   sample_valid;
   logic                   pwm;
   logic                   underrun;

   int checks = 0;
   int errors = 0;

   int pos = 1000;
   int acc_high = 0;
   int period_high = 0;
   int acc_valid = 0;
   int period_valid = 0;

   int         gen_pos = 5;
   logic [2:0] gen_mask = 3'b000;
   logic [7:0] gen_data [3];
   logic [7:0] sb_q [$];

   waveform_pwm_output_if #(.N_FRAC(N_FRAC)) bus ();

   waveform_pwm_output #(.N_FRAC(N_FRAC)) dut (
      .clk_i                 (clk),
      .rst_i                 (rst),
      .wave_select_i         (wave_select),
      .gen                   (bus),
      .sample_o              (sample),
      .sample_valid_strobe_o (sample_valid),
      .pwm_o                 (pwm),
      .underrun_o            (underrun)
   );

   // Free-running system clock.
   always #5 clk = ~clk;

   // One cycle: observe at the falling edge, score sample updates, then drive
   // the generator strobes for the coming rising edge.
   task automatic applyStimulus();
      logic [7:0] got;
      logic [7:0] exp;
      @(negedge clk);
      if (bus.next_data_strobe_o) pos = 0;
      else pos = pos + 1;
      if (pos == 0) begin
         period_high  = acc_high + (pwm ? 1 : 0);
         period_valid = acc_valid + (sample_valid ? 1 : 0);
         acc_high     = 0;
         acc_valid    = 0;
      end else begin
         if (pwm) acc_high = acc_high + 1;
         if (sample_valid) acc_valid = acc_valid + 1;
      end
      if (sample_valid) begin
         got = sample;
         checks++;
         if (sb_q.size() == 0) begin
            errors++;
            $display("[TB] FAIL sb_unexpected sample_o=%02h with no expected entry", got);
         end else begin
            exp = sb_q.pop_front();
            if (got !== exp) begin
               errors++;
               $display("[TB] FAIL sb_sample got %02h expected %02h", got, exp);
            end
         end
      end
      bus.data_sawtooth_valid_strobe_i    = 1'b0;
      bus.data_triangle_valid_strobe_i    = 1'b0;
      bus.data_square_puls_valid_strobe_i = 1'b0;
      bus.data_sawtooth_i                 = ~gen_data[0];
      bus.data_triangle_i                 = ~gen_data[1];
      bus.data_square_puls_i              = ~gen_data[2];
      if (pos == gen_pos) begin
         if (gen_mask[0]) begin
            bus.data_sawtooth_valid_strobe_i = 1'b1;
            bus.data_sawtooth_i              = gen_data[0];
         end
         if (gen_mask[1]) begin
            bus.data_triangle_valid_strobe_i = 1'b1;
            bus.data_triangle_i              = gen_data[1];
         end
         if (gen_mask[2]) begin
            bus.data_square_puls_valid_strobe_i = 1'b1;
            bus.data_square_puls_i              = gen_data[2];
         end
      end
   endtask

   // Advance to the next cnt = 0 cycle, bounded.
   task automatic wait_wrap(input string tag);
      int n;
      n = 0;
      do begin
         applyStimulus();
         n++;
      end while (pos != 0 && n < 300);
      checks++;
      if (pos != 0) begin
         errors++;
         $display("[TB] FAIL %s wrap_timeout got %0d cycles without request, required <=256", tag, n);
      end
   endtask

   // Advance to a given period position, bounded.
   task automatic wait_pos(input int target);
      int n;
      n = 0;
      do begin
         applyStimulus();
         n++;
      end while (pos != target && n < 300);
      checks++;
      if (pos != target) begin
         errors++;
         $display("[TB] FAIL pos_timeout got pos %0d required %0d", pos, target);
      end
   endtask

   task automatic test_reset();
      for (int i = 0; i < 3; i++) applyStimulus();
      checks++;
      if (pwm !== 1'b0 || underrun !== 1'b0 || bus.next_data_strobe_o !== 1'b0 ||
          sample_valid !== 1'b0 || sample !== 8'sh00) begin
         errors++;
         $display("[TB] FAIL reset_values got pwm=%b und=%b nxt=%b vld=%b smp=%02h required 0 0 0 0 00",
                  pwm, underrun, bus.next_data_strobe_o, sample_valid, sample);
      end
      rst = 1'b0;
      applyStimulus();
      checks++;
      if (bus.next_data_strobe_o !== 1'b1 || pwm !== 1'b0) begin
         errors++;
         $display("[TB] FAIL reset_release got nxt=%b pwm=%b required nxt=1 pwm=0",
                  bus.next_data_strobe_o, pwm);
      end
   endtask

   task automatic test_sawtooth();
      wave_select = 2'b00;
      gen_mask    = 3'b001;
      gen_data[0] = 8'h40;
      sb_q.push_back(8'h00);
      wait_wrap("saw_w1");
      sb_q.push_back(8'h40);
      wait_wrap("saw_w2");
      checks++;
      if (sample !== 8'sh40 || underrun !== 1'b0) begin
         errors++;
         $display("[TB] FAIL saw_period3 got smp=%02h und=%b required 40 0", sample, underrun);
      end
      sb_q.push_back(8'h40);
      wait_wrap("saw_w3");
      checks++;
      if (period_high != 192) begin
         errors++;
         $display("[TB] FAIL saw_duty got %0d high cycles required 192", period_high);
      end
   endtask

   task automatic test_triangle();
      wave_select = 2'b01;
      gen_mask    = 3'b011;
      gen_data[1] = 8'h80;
      sb_q.push_back(8'h40);
      wait_wrap("tri_w4");
      sb_q.push_back(8'h80);
      wait_wrap("tri_w5");
      gen_data[1] = 8'h7F;
      sb_q.push_back(8'h7F);
      wait_wrap("tri_w6");
      checks++;
      if (period_high != 0 || period_valid != 1) begin
         errors++;
         $display("[TB] FAIL tri_min got high=%0d valid=%0d required 0 1", period_high, period_valid);
      end
      sb_q.push_back(8'h7F);
      wait_wrap("tri_w7");
      checks++;
      if (period_high != 255 || period_valid != 1 || underrun !== 1'b0) begin
         errors++;
         $display("[TB] FAIL tri_max got high=%0d valid=%0d und=%b required 255 1 0",
                  period_high, period_valid, underrun);
      end
   endtask

   task automatic test_mute();
      wave_select = 2'b11;
      sb_q.push_back(8'h7F);
      wait_wrap("mute_w8");
      gen_mask = 3'b000;
      for (int i = 0; i < 5; i++) begin
         sb_q.push_back(8'h00);
         wait_wrap("mute_loop");
         checks++;
         if (sample !== 8'sh00 || underrun !== 1'b0) begin
            errors++;
            $display("[TB] FAIL mute_state[%0d] got smp=%02h und=%b required 00 0", i, sample, underrun);
         end
         if (i >= 1) begin
            checks++;
            if (period_high != 128) begin
               errors++;
               $display("[TB] FAIL mute_duty[%0d] got %0d high cycles required 128", i, period_high);
            end
         end
      end
   endtask

   task automatic test_select_change();
      wave_select = 2'b00;
      gen_mask    = 3'b101;
      gen_data[0] = 8'h20;
      gen_data[2] = 8'hE0;
      sb_q.push_back(8'h00);
      wait_wrap("sel_w14");
      wait_pos(100);
      wave_select = 2'b10;
      sb_q.push_back(8'h20);
      wait_wrap("sel_w15");
      checks++;
      if (sample !== 8'sh20) begin
         errors++;
         $display("[TB] FAIL sel_old_stream got %02h required 20", sample);
      end
      sb_q.push_back(8'hE0);
      wait_wrap("sel_w16");
      checks++;
      if (sample !== 8'shE0) begin
         errors++;
         $display("[TB] FAIL sel_new_stream got %02h required e0", sample);
      end
      sb_q.push_back(8'hE0);
      wait_wrap("sel_w17");
      checks++;
      if (period_high != 96) begin
         errors++;
         $display("[TB] FAIL sel_duty got %0d high cycles required 96", period_high);
      end
   endtask

   task automatic test_underrun();
      wave_select = 2'b00;
      gen_data[0] = 8'h40;
      sb_q.push_back(8'hE0);
      wait_wrap("und_w18");
      sb_q.push_back(8'h40);
      wait_wrap("und_w19");
      checks++;
      if (sample !== 8'sh40 || underrun !== 1'b0) begin
         errors++;
         $display("[TB] FAIL und_before got smp=%02h und=%b required 40 0", sample, underrun);
      end
      gen_mask = 3'b000;
      wait_wrap("und_w20");
      checks++;
      if (underrun !== 1'b1 || sample !== 8'sh40 || period_valid != 0) begin
         errors++;
         $display("[TB] FAIL und_set got und=%b smp=%02h valid=%0d required 1 40 0",
                  underrun, sample, period_valid);
      end
      gen_mask = 3'b001;
      sb_q.push_back(8'h40);
      wait_wrap("und_w21");
      checks++;
      if (period_high != 192 || underrun !== 1'b1) begin
         errors++;
         $display("[TB] FAIL und_hold got high=%0d und=%b required 192 1", period_high, underrun);
      end
      sb_q.push_back(8'h40);
      wait_wrap("und_w22");
      checks++;
      if (underrun !== 1'b1) begin
         errors++;
         $display("[TB] FAIL und_sticky got %b required 1", underrun);
      end
   endtask

   task automatic test_boundary_reset();
      gen_pos     = 255;
      gen_mask    = 3'b001;
      gen_data[0] = 8'h10;
      sb_q.push_back(8'h10);
      wait_wrap("edge_w23");
      checks++;
      if (sample !== 8'sh10 || period_valid != 1) begin
         errors++;
         $display("[TB] FAIL edge_bypass got smp=%02h valid=%0d required 10 1", sample, period_valid);
      end
      gen_mask = 3'b000;
      wait_wrap("edge_w24");
      checks++;
      if (sample !== 8'sh10 || period_valid != 0) begin
         errors++;
         $display("[TB] FAIL edge_no_fresh got smp=%02h valid=%0d required 10 0", sample, period_valid);
      end
      gen_pos  = 79;
      gen_mask = 3'b001;
      wait_pos(77);
      rst = 1'b1;
      for (int i = 0; i < 3; i++) applyStimulus();
      checks++;
      if (pwm !== 1'b0 || underrun !== 1'b0 || sample !== 8'sh00 || bus.next_data_strobe_o !== 1'b0) begin
         errors++;
         $display("[TB] FAIL midreset got pwm=%b und=%b smp=%02h nxt=%b required 0 0 00 0",
                  pwm, underrun, sample, bus.next_data_strobe_o);
      end
      rst      = 1'b0;
      gen_mask = 3'b000;
      applyStimulus();
      checks++;
      if (bus.next_data_strobe_o !== 1'b1 || pwm !== 1'b0 || underrun !== 1'b0) begin
         errors++;
         $display("[TB] FAIL midreset_release got nxt=%b pwm=%b und=%b required 1 0 0",
                  bus.next_data_strobe_o, pwm, underrun);
      end
      sb_q.push_back(8'h00);
      wait_wrap("post_reset");
      checks++;
      if (period_high != 128 || underrun !== 1'b0 || sample !== 8'sh00) begin
         errors++;
         $display("[TB] FAIL post_reset_period got high=%0d und=%b smp=%02h required 128 0 00",
                  period_high, underrun, sample);
      end
   endtask

   // Run every scenario in sequence on one continuous timeline.
   initial begin
      gen_data[0] = 8'h00;
      gen_data[1] = 8'h00;
      gen_data[2] = 8'h00;
      bus.data_sawtooth_i                 = '0;
      bus.data_sawtooth_valid_strobe_i    = 1'b0;
      bus.data_triangle_i                 = '0;
      bus.data_triangle_valid_strobe_i    = 1'b0;
      bus.data_square_puls_i              = '0;
      bus.data_square_puls_valid_strobe_i = 1'b0;
      test_reset();
      test_sawtooth();
      test_triangle();
      test_mute();
      test_select_change();
      test_underrun();
      test_boundary_reset();
      checks++;
      if (sb_q.size() != 0) begin
         errors++;
         $display("[TB] FAIL sb_leftover got %0d pending entries required 0", sb_q.size());
      end
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
